// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: requester IDs and read-tag type shared by ram_access_arb and rr_arb2.
// RAM_ARB_COLLISION_BYPASS_EN adds the collision-hit flag to the read tag.
package ram_arb_pkg;
   typedef logic req_id_t;
   localparam req_id_t REQ_M0 = 1'b0;
   localparam req_id_t REQ_M1 = 1'b1;
   typedef struct packed {
      logic    valid;
      req_id_t id;
`ifdef RAM_ARB_COLLISION_BYPASS_EN
      logic    hit;
`endif
   } rd_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; pointer holds the last granted requester.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   req_id_t last_q, last_d;
   always_comb begin
      gnt_o  = (&req_i) ? ((last_q == REQ_M1) ? 2'b01 : 2'b10) : req_i;
      last_d = gnt_o[0] ? REQ_M0 : gnt_o[1] ? REQ_M1 : last_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_q <= REQ_M1;
      else last_q <= last_d;
endmodule

// File: rtl/ram_access_arb.sv
// ram_access_arb: shares a simple-dual-port RAM between two requesters with independent write/read arbitration.
// RAM_ARB_COLLISION_BYPASS_EN: a same-cycle write/read to one address returns the write data to the reader.
module ram_access_arb
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              ram_wea_o,
   output logic [ADDR_W-1:0] ram_addra_o,
   output logic [DATA_W-1:0] ram_dina_o,
   output logic [ADDR_W-1:0] ram_addrb_o,
   input  logic [DATA_W-1:0] ram_doutb_i
);
   localparam int TW = $bits(rd_tag_t);
   logic [1:0] wr_req, rd_req, wr_gnt, rd_gnt;
   logic [ADDR_W-1:0] wr_addr_d, rd_addr_d, addra_q, addrb_q;
   logic [DATA_W-1:0] wr_data_d, dina_q, ret_data, m0_rdata_q, m1_rdata_q;
   logic wea_q, m0_rvalid_q, m1_rvalid_q;
   rd_tag_t tag_d, tag_o;
   rd_tag_t [RD_LAT-1:0] tag_q;
   // Grants are held off while reset is asserted so nothing is accepted and then lost.
   assign wr_req = {m1_req_i & m1_we_i, m0_req_i & m0_we_i} & {2{rst_n}};
   assign rd_req = {m1_req_i & ~m1_we_i, m0_req_i & ~m0_we_i} & {2{rst_n}};
   rr_arb2 u_wr_arb (.clk(clk), .rst_n(rst_n), .req_i(wr_req), .gnt_o(wr_gnt));
   rr_arb2 u_rd_arb (.clk(clk), .rst_n(rst_n), .req_i(rd_req), .gnt_o(rd_gnt));
   assign m0_gnt_o = wr_gnt[0] | rd_gnt[0];
   assign m1_gnt_o = wr_gnt[1] | rd_gnt[1];
   always_comb begin
      tag_d       = '0;
      wr_addr_d   = wr_gnt[1] ? m1_addr_i : m0_addr_i;
      wr_data_d   = wr_gnt[1] ? m1_wdata_i : m0_wdata_i;
      rd_addr_d   = rd_gnt[1] ? m1_addr_i : m0_addr_i;
      tag_d.valid = |rd_gnt;
      tag_d.id    = rd_gnt[1] ? REQ_M1 : REQ_M0;
`ifdef RAM_ARB_COLLISION_BYPASS_EN
      tag_d.hit   = (|rd_gnt) && (|wr_gnt) && (rd_addr_d == wr_addr_d);
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wea_q   <= 1'b0;
         addra_q <= '0;
         dina_q  <= '0;
         addrb_q <= '0;
         tag_q   <= '0;
      end else begin
         wea_q <= |wr_gnt;
         if (|wr_gnt) begin
            addra_q <= wr_addr_d;
            dina_q  <= wr_data_d;
         end
         if (|rd_gnt) addrb_q <= rd_addr_d;
         tag_q <= (RD_LAT*TW)'({tag_q, tag_d});
      end
   assign tag_o = tag_q[RD_LAT-1];
`ifdef RAM_ARB_COLLISION_BYPASS_EN
   logic [RD_LAT-1:0][DATA_W-1:0] byp_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) byp_q <= '0;
      else byp_q <= (RD_LAT*DATA_W)'({byp_q, wr_data_d});
   assign ret_data = tag_o.hit ? byp_q[RD_LAT-1] : ram_doutb_i;
`else
   assign ret_data = ram_doutb_i;
`endif
   // The last tag stage lines up with doutb, so capturing here gives rvalid RD_LAT+1 cycles after grant.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= tag_o.valid && tag_o.id == REQ_M0;
         m1_rvalid_q <= tag_o.valid && tag_o.id == REQ_M1;
         if (tag_o.valid && tag_o.id == REQ_M0) m0_rdata_q <= ret_data;
         if (tag_o.valid && tag_o.id == REQ_M1) m1_rdata_q <= ret_data;
      end
   assign ram_wea_o   = wea_q;
   assign ram_addra_o = addra_q;
   assign ram_dina_o  = dina_q;
   assign ram_addrb_o = addrb_q;
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
endmodule
